en_pulse_counter: RTL and testbench

//   Free-running modulo-DIV prescaler that produces a periodic enable strobe (en)

---
 rtl/en_pulse_counter_if.sv | 23 ++
 rtl/en_pulse_counter.sv | 58 +++++
 tb/tb_en_pulse_counter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/en_pulse_counter_if.sv
// Output bundle of the enable-strobe prescaler: the strobe itself and the
// exported phase counter. The counter width is derived from DIV exactly as
// inside the prescaler, so both sides must be given the same DIV.
interface en_pulse_counter_if #(
    parameter int unsigned DIV = 10
);
    localparam int unsigned CW = (DIV <= 1) ? 1 : $clog2(DIV);

    logic          en;
    logic [CW-1:0] cnt;

    // Prescaler side drives both signals
    modport master (
        output en,
        output cnt
    );

    // Consumers (CRYPT stages, debug, phase alignment) only observe
    modport slave (
        input en,
        input cnt
    );
endinterface

// File: rtl/en_pulse_counter.sv
// Free-running modulo-DIV prescaler producing a periodic clock-enable strobe.
// en is high while the phase counter sits in [DIV-PULSE_W, DIV-1]; both the
// counter and the strobe come straight from flops, so there is no
// combinational path to either output.
module en_pulse_counter #(
    parameter int unsigned DIV     = 10,
    parameter int unsigned PULSE_W = 1
) (
    input  logic               CLK,
    input  logic               RST,
    en_pulse_counter_if.master bus
);
    localparam int unsigned   CW       = (DIV <= 1) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
    localparam int unsigned   THRESH_I = DIV - PULSE_W;

    // Reject illegal configurations at elaboration; nothing is checked at run time
    if (DIV < 1 || PULSE_W < 1 || PULSE_W > DIV) begin : g_bad_params
        $error("en_pulse_counter: need 1 <= PULSE_W <= DIV and DIV >= 1");
    end

    logic [CW-1:0] r_cnt;
    logic          r_en;
    logic [CW-1:0] w_cnt_next;
    logic          w_wrap;
    logic          w_en_next;

    // Next phase: exact wrap at DIV-1, so values >= DIV are never reached
    always_comb begin
        w_wrap     = (r_cnt == LAST);
        w_cnt_next = w_wrap ? '0 : r_cnt + 1'b1;
    end

    // Strobe decode is taken from the next count so en lines up with cnt
    // with zero lag once both are registered. A zero threshold means the
    // strobe is permanently high (PULSE_W == DIV, including DIV == 1).
    if (THRESH_I == 0) begin : g_en_always
        assign w_en_next = 1'b1;
    end else begin : g_en_decode
        localparam logic [CW-1:0] THRESH = CW'(THRESH_I);
        assign w_en_next = (w_cnt_next >= THRESH);
    end

    // Phase counter and strobe flops; reset clears both at once, mid-period
    // included, so no partial strobe survives a reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
            r_en  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_en  <= w_en_next;
        end
    end

    assign bus.cnt = r_cnt;
    assign bus.en  = r_en;
endmodule

// File: tb/tb_en_pulse_counter.sv
// Bench for en_pulse_counter: several configurations run side by side on a
// shared clock and reset and are compared against an arithmetic model based
// on the number of rising edges seen since reset was released.
module tb_en_pulse_counter;
    localparam int N = 6;
    localparam int unsigned DIVS [N] = '{10, 10, 1, 4, 16777216, 7};
    localparam int unsigned PWS  [N] = '{1, 3, 1, 4, 1, 2};

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    int          errors = 0;
    int          checks = 0;
    int unsigned e = 0;      // rising edges since reset release

    logic        got_en  [N];
    logic [31:0] got_cnt [N];

    always #20 CLK = ~CLK;

    en_pulse_counter_if #(.DIV(10))       if0 ();
    en_pulse_counter_if #(.DIV(10))       if1 ();
    en_pulse_counter_if #(.DIV(1))        if2 ();
    en_pulse_counter_if #(.DIV(4))        if3 ();
    en_pulse_counter_if #(.DIV(16777216)) if4 ();
    en_pulse_counter_if #(.DIV(7))        if5 ();

    en_pulse_counter #(.DIV(10),       .PULSE_W(1)) u0 (.CLK(CLK), .RST(RST), .bus(if0));
    en_pulse_counter #(.DIV(10),       .PULSE_W(3)) u1 (.CLK(CLK), .RST(RST), .bus(if1));
    en_pulse_counter #(.DIV(1),        .PULSE_W(1)) u2 (.CLK(CLK), .RST(RST), .bus(if2));
    en_pulse_counter #(.DIV(4),        .PULSE_W(4)) u3 (.CLK(CLK), .RST(RST), .bus(if3));
    en_pulse_counter #(.DIV(16777216), .PULSE_W(1)) u4 (.CLK(CLK), .RST(RST), .bus(if4));
    en_pulse_counter #(.DIV(7),        .PULSE_W(2)) u5 (.CLK(CLK), .RST(RST), .bus(if5));

    assign got_en[0]  = if0.en;
    assign got_en[1]  = if1.en;
    assign got_en[2]  = if2.en;
    assign got_en[3]  = if3.en;
    assign got_en[4]  = if4.en;
    assign got_en[5]  = if5.en;
    assign got_cnt[0] = 32'(if0.cnt);
    assign got_cnt[1] = 32'(if1.cnt);
    assign got_cnt[2] = 32'(if2.cnt);
    assign got_cnt[3] = 32'(if3.cnt);
    assign got_cnt[4] = 32'(if4.cnt);
    assign got_cnt[5] = 32'(if5.cnt);

    // Reference: after k edges the phase is k mod DIV; the strobe is high in
    // the last PULSE_W phases of each period; in reset both are zero.
    function automatic logic [31:0] m_cnt(int d, int unsigned k);
        if (k == 0) return 32'd0;
        return 32'(k % DIVS[d]);
    endfunction

    function automatic logic m_en(int d, int unsigned k);
        if (k == 0) return 1'b0;
        return ((k % DIVS[d]) >= (DIVS[d] - PWS[d]));
    endfunction

    task automatic step();
        @(posedge CLK);
        if (!RST) e++;
        @(negedge CLK);
    endtask

    task automatic release_rst();
        @(negedge CLK);
        RST = 1'b0;
        e   = 0;
    endtask

    task automatic test_reset();
        #90;
        for (int d = 0; d < N; d++) begin
            checks++;
            if (got_cnt[d] !== 32'd0) begin
                errors++;
                $display("FAIL reset_cnt dut%0d: got %0d, expected 0", d, got_cnt[d]);
            end
            checks++;
            if (got_en[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_en dut%0d: got %b, expected 0", d, got_en[d]);
            end
        end
        release_rst();
    endtask

    task automatic test_first_strobe();
        int rise [N];
        for (int d = 0; d < N; d++) rise[d] = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            for (int d = 0; d < N; d++) begin
                if (got_en[d] === 1'b1 && rise[d] < 0) rise[d] = i;
                checks++;
                if (got_cnt[d] !== m_cnt(d, e)) begin
                    errors++;
                    $display("FAIL first_cnt dut%0d edge%0d: got %0d, expected %0d",
                             d, i, got_cnt[d], m_cnt(d, e));
                end
            end
        end
        checks++;
        if (rise[0] !== 9) begin
            errors++;
            $display("FAIL first_rise_div10_pw1: got edge %0d, expected 9", rise[0]);
        end
        checks++;
        if (rise[1] !== 7) begin
            errors++;
            $display("FAIL first_rise_div10_pw3: got edge %0d, expected 7", rise[1]);
        end
        checks++;
        if (rise[5] !== 5) begin
            errors++;
            $display("FAIL first_rise_div7_pw2: got edge %0d, expected 5", rise[5]);
        end
        checks++;
        if (rise[2] !== 1) begin
            errors++;
            $display("FAIL first_rise_div1: got edge %0d, expected 1", rise[2]);
        end
    endtask

    task automatic test_period();
        time t_prev [2];
        logic prev [2];
        int   high_run;
        prev[0]   = got_en[0];
        prev[1]   = got_en[1];
        t_prev[0] = 0;
        t_prev[1] = 0;
        high_run  = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                if (got_en[d] === 1'b1 && prev[d] === 1'b0) begin
                    if (t_prev[d] != 0) begin
                        checks++;
                        if ($time - t_prev[d] != 400) begin
                            errors++;
                            $display("FAIL period dut%0d: got %0t, expected 400",
                                     d, $time - t_prev[d]);
                        end
                    end
                    t_prev[d] = $time;
                end
                prev[d] = got_en[d];
            end
            if (got_en[1] === 1'b1) begin
                high_run++;
            end else begin
                if (high_run != 0) begin
                    checks++;
                    if (high_run != 3) begin
                        errors++;
                        $display("FAIL pulse_width_pw3: got %0d, expected 3", high_run);
                    end
                end
                high_run = 0;
            end
        end
    endtask

    task automatic test_async_mid();
        int found;
        int rise;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (got_cnt[0] === 32'd5) found = 1;
            else step();
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL async_wait_cnt5: got %0d, expected 5 within 20 cycles", got_cnt[0]);
        end
        #5;
        RST = 1'b1;
        e   = 0;
        #1;
        for (int d = 0; d < N; d++) begin
            checks++;
            if (got_cnt[d] !== 32'd0 || got_en[d] !== 1'b0) begin
                errors++;
                $display("FAIL async_clear dut%0d: got cnt=%0d en=%b, expected cnt=0 en=0",
                         d, got_cnt[d], got_en[d]);
            end
        end
        step();
        checks++;
        if (got_cnt[0] !== 32'd0) begin
            errors++;
            $display("FAIL async_hold: got %0d, expected 0", got_cnt[0]);
        end
        release_rst();
        rise = -1;
        for (int i = 1; i <= 20 && rise < 0; i++) begin
            step();
            if (got_en[0] === 1'b1) rise = i;
        end
        checks++;
        if (rise !== 9) begin
            errors++;
            $display("FAIL async_restart_rise: got edge %0d, expected 9", rise);
        end
    endtask

    task automatic test_corners();
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (got_cnt[2] !== 32'd0 || got_en[2] !== 1'b1) begin
                errors++;
                $display("FAIL div1: got cnt=%0d en=%b, expected cnt=0 en=1",
                         got_cnt[2], got_en[2]);
            end
            checks++;
            if (got_en[3] !== 1'b1 || got_cnt[3] !== 32'(e % 4)) begin
                errors++;
                $display("FAIL div4_pw4: got cnt=%0d en=%b, expected cnt=%0d en=1",
                         got_cnt[3], got_en[3], e % 4);
            end
            checks++;
            if (got_cnt[4] !== 32'(e) || got_en[4] !== 1'b0) begin
                errors++;
                $display("FAIL div2p24: got cnt=%0d en=%b, expected cnt=%0d en=0",
                         got_cnt[4], got_en[4], e);
            end
        end
    endtask

    task automatic test_scoreboard();
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                #($urandom_range(1, 15));
                RST = 1'b1;
                e   = 0;
                #1;
                for (int d = 0; d < N; d++) begin
                    checks++;
                    if (got_cnt[d] !== 32'd0 || got_en[d] !== 1'b0) begin
                        errors++;
                        $display("FAIL sb_reset dut%0d: got cnt=%0d en=%b, expected 0/0",
                                 d, got_cnt[d], got_en[d]);
                    end
                end
                repeat ($urandom_range(1, 3)) step();
                release_rst();
            end else begin
                step();
                for (int d = 0; d < N; d++) begin
                    checks++;
                    if ($isunknown(got_en[d]) || got_en[d] !== m_en(d, e) ||
                        got_cnt[d] !== m_cnt(d, e)) begin
                        errors++;
                        $display("FAIL sb dut%0d k=%0d: got cnt=%0d en=%b, expected cnt=%0d en=%b",
                                 d, e, got_cnt[d], got_en[d], m_cnt(d, e), m_en(d, e));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_strobe();
        test_period();
        test_async_mid();
        test_corners();
        test_scoreboard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
